// File: rtl/instr_decode_stage_if.sv
// Handshake and field bus between fetch, the decode stage and register read.
// Ports: in_valid/in_ready/instruction (fetch side), out_valid/out_ready plus
//        decoded fields (register-read side), count (FIFO occupancy).
// Optional INSTR_DEC_CLASSIFY_EN adds is_rtype/is_jtype/is_branch/is_mem.
interface instr_decode_stage_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   // fetch side
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       instruction;

   // register-read side
   logic              out_valid;
   logic              out_ready;
   logic [5:0]        opcode;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [4:0]        shamt;
   logic [5:0]        func;
   logic [15:0]       immediate;
   logic [DATA_W-1:0] imm_ext;
   logic [25:0]       jump_target;
   logic [CNT_W-1:0]  count;
`ifdef INSTR_DEC_CLASSIFY_EN
   logic              is_rtype;
   logic              is_jtype;
   logic              is_branch;
   logic              is_mem;
`endif

   // master: the environment (fetch producer + register-read consumer)
   modport master (
      output in_valid, instruction, out_ready,
      input  in_ready, out_valid, opcode, rs, rt, rd, shamt, func,
             immediate, imm_ext, jump_target, count
`ifdef INSTR_DEC_CLASSIFY_EN
      , input is_rtype, is_jtype, is_branch, is_mem
`endif
   );

   // slave: the decode stage itself
   modport slave (
      input  in_valid, instruction, out_ready,
      output in_ready, out_valid, opcode, rs, rt, rd, shamt, func,
             immediate, imm_ext, jump_target, count
`ifdef INSTR_DEC_CLASSIFY_EN
      , output is_rtype, is_jtype, is_branch, is_mem
`endif
   );
endinterface

// File: rtl/instr_decode_stage.sv
// Purpose: DEPTH-entry instruction FIFO feeding a held MIPS field-decode register.
// Latency: word pushed at edge N is presented after edge N+1 at the earliest (no bypass).
// Backpressure: in_ready drops only when the FIFO is full; out_valid holds until out_ready.
//
// Ports: clk, rst (sync, active-high), state (pop/decode only in FIELDS_STATE),
//        flush (drops FIFO contents and out_valid, fields hold),
//        bus (instr_decode_stage_if.slave: input handshake, output handshake,
//        decoded fields, occupancy count). Bus DATA_W/DEPTH must match this module's.
// Optional feature macro: INSTR_DEC_CLASSIFY_EN adds registered instruction-class flags.
module instr_decode_stage #(
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 4,
   parameter int STATE_W      = 3,
   parameter int FIELDS_STATE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STATE_W-1:0] state,
   input  logic               flush,
   instr_decode_stage_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [STATE_W-1:0] DEC_STATE = STATE_W'(FIELDS_STATE);

   // ---------------- FIFO ----------------
   logic [31:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             full;
   logic             in_rdy;
   logic             push;
   logic             load;
   logic             out_vld;

   assign full   = (cnt == FULL_CNT);
   // Readiness depends only on occupancy and reset, never on a same-cycle pop,
   // so a full FIFO always refuses even while it is draining.
   assign in_rdy = !full && !rst;
   // A flush cycle swallows whatever is offered.
   assign push   = bus.in_valid && in_rdy && !flush;
   // Pop only when the output register is free or being consumed this cycle.
   assign load   = (state == DEC_STATE) && (cnt != '0) &&
                   (!out_vld || bus.out_ready) && !flush;

   // Storage needs no reset: entries are only read when counted valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.instruction;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally.
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (load) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, load})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // ---------------- Decode of the FIFO head ----------------
   logic [31:0]       head;
   logic [5:0]        head_op;
   logic [15:0]       head_imm;
   logic [DATA_W-1:0] ext_nxt;

   assign head     = mem[rd_ptr];
   assign head_op  = head[31:26];
   assign head_imm = head[15:0];

   // Logical-immediate ops zero-extend, lui places the immediate in the
   // upper half, everything else (arith, branch, load/store) sign-extends.
   always_comb begin
      ext_nxt = DATA_W'({{DATA_W{head_imm[15]}}, head_imm});
      case (head_op)
         6'h0C, 6'h0D, 6'h0E: ext_nxt = DATA_W'({{DATA_W{1'b0}}, head_imm});
         6'h0F:               ext_nxt = DATA_W'({{DATA_W{1'b0}}, head_imm, 16'h0000});
         default:             ext_nxt = DATA_W'({{DATA_W{head_imm[15]}}, head_imm});
      endcase
   end

`ifdef INSTR_DEC_CLASSIFY_EN
   logic cls_r_nxt;
   logic cls_j_nxt;
   logic cls_b_nxt;
   logic cls_m_nxt;

   always_comb begin
      cls_r_nxt = (head_op == 6'h00);
      cls_j_nxt = (head_op == 6'h02) || (head_op == 6'h03);
      cls_b_nxt = (head_op == 6'h01) || (head_op == 6'h04) || (head_op == 6'h05) ||
                  (head_op == 6'h06) || (head_op == 6'h07);
      // All loads and stores live in the upper half of the opcode space.
      cls_m_nxt = head_op[5];
   end
`endif

   // ---------------- Output register ----------------
   logic [5:0]        opcode_q;
   logic [4:0]        rs_q;
   logic [4:0]        rt_q;
   logic [4:0]        rd_q;
   logic [4:0]        shamt_q;
   logic [5:0]        func_q;
   logic [15:0]       imm_q;
   logic [DATA_W-1:0] ext_q;
   logic [25:0]       jt_q;
`ifdef INSTR_DEC_CLASSIFY_EN
   logic              is_rtype_q;
   logic              is_jtype_q;
   logic              is_branch_q;
   logic              is_mem_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld  <= 1'b0;
         opcode_q <= '0;
         rs_q     <= '0;
         rt_q     <= '0;
         rd_q     <= '0;
         shamt_q  <= '0;
         func_q   <= '0;
         imm_q    <= '0;
         ext_q    <= '0;
         jt_q     <= '0;
`ifdef INSTR_DEC_CLASSIFY_EN
         is_rtype_q  <= 1'b0;
         is_jtype_q  <= 1'b0;
         is_branch_q <= 1'b0;
         is_mem_q    <= 1'b0;
`endif
      end else if (flush) begin
         // Fields deliberately hold; only the valid is withdrawn.
         out_vld <= 1'b0;
      end else if (load) begin
         out_vld  <= 1'b1;
         opcode_q <= head[31:26];
         rs_q     <= head[25:21];
         rt_q     <= head[20:16];
         rd_q     <= head[15:11];
         shamt_q  <= head[10:6];
         func_q   <= head[5:0];
         imm_q    <= head_imm;
         ext_q    <= ext_nxt;
         jt_q     <= head[25:0];
`ifdef INSTR_DEC_CLASSIFY_EN
         is_rtype_q  <= cls_r_nxt;
         is_jtype_q  <= cls_j_nxt;
         is_branch_q <= cls_b_nxt;
         is_mem_q    <= cls_m_nxt;
`endif
      end else if (out_vld && bus.out_ready) begin
         out_vld <= 1'b0;
      end
   end

   assign bus.in_ready    = in_rdy;
   assign bus.out_valid   = out_vld;
   assign bus.opcode      = opcode_q;
   assign bus.rs          = rs_q;
   assign bus.rt          = rt_q;
   assign bus.rd          = rd_q;
   assign bus.shamt       = shamt_q;
   assign bus.func        = func_q;
   assign bus.immediate   = imm_q;
   assign bus.imm_ext     = ext_q;
   assign bus.jump_target = jt_q;
   assign bus.count       = cnt;
`ifdef INSTR_DEC_CLASSIFY_EN
   assign bus.is_rtype    = is_rtype_q;
   assign bus.is_jtype    = is_jtype_q;
   assign bus.is_branch   = is_branch_q;
   assign bus.is_mem      = is_mem_q;
`endif
endmodule

// File: tb/tb_instr_decode_stage.sv
// Purpose: scoreboard bench for instr_decode_stage with hand-decoded MIPS vectors.
// Latency: stimulus pushes expectations on acceptance; monitor pops on each output transfer.
// Backpressure: exercised by holding out_ready low until the FIFO fills.
module tb_instr_decode_stage;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] state;
   logic       flush;

   always #5 clk = ~clk;

   instr_decode_stage_if #(.DATA_W(32), .DEPTH(4)) bus ();

   instr_decode_stage #(
      .DATA_W(32), .DEPTH(4), .STATE_W(3), .FIELDS_STATE(1)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .state (state),
      .flush (flush),
      .bus   (bus)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sh;
      logic [5:0]  fn;
      logic [15:0] imm;
      logic [31:0] ext;
      logic [25:0] jt;
      logic [3:0]  cls;   // {rtype, jtype, branch, mem}
   } vec_t;

   vec_t vecs [12];
   vec_t sb [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every completed output transfer against the scoreboard.
   always @(negedge clk) begin
      if (!rst && !flush && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 32'(bus.opcode), 32'hDEADBEEF);
         end else begin
            vec_t e;
            e = sb.pop_front();
            check("opcode",      32'(bus.opcode),      32'(e.op));
            check("rs",          32'(bus.rs),          32'(e.rs));
            check("rt",          32'(bus.rt),          32'(e.rt));
            check("rd",          32'(bus.rd),          32'(e.rd));
            check("shamt",       32'(bus.shamt),       32'(e.sh));
            check("func",        32'(bus.func),        32'(e.fn));
            check("immediate",   32'(bus.immediate),   32'(e.imm));
            check("imm_ext",     bus.imm_ext,          e.ext);
            check("jump_target", 32'(bus.jump_target), 32'(e.jt));
`ifdef INSTR_DEC_CLASSIFY_EN
            check("class", 32'({bus.is_rtype, bus.is_jtype, bus.is_branch, bus.is_mem}),
                  32'(e.cls));
`endif
         end
      end
   end

   // Offer one word; expectation is queued once the DUT accepts it.
   task automatic push_vec(input int idx);
      bit done = 0;
      bus.instruction = vecs[idx].instr;
      bus.in_valid    = 1'b1;
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back(vecs[idx]);
            @(posedge clk);
            #1;
            done = 1;
         end
      end
      bus.in_valid = 1'b0;
      if (!done) check("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
      #1;
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_out_valid"}, 32'(bus.out_valid),   32'd0);
      check({tag, "_count"},     32'(bus.count),       32'd0);
      check({tag, "_opcode"},    32'(bus.opcode),      32'd0);
      check({tag, "_rs_rt_rd"},  32'({bus.rs, bus.rt, bus.rd}), 32'd0);
      check({tag, "_sh_fn"},     32'({bus.shamt, bus.func}),    32'd0);
      check({tag, "_imm"},       32'(bus.immediate),   32'd0);
      check({tag, "_imm_ext"},   bus.imm_ext,          32'd0);
      check({tag, "_jt"},        32'(bus.jump_target), 32'd0);
`ifdef INSTR_DEC_CLASSIFY_EN
      check({tag, "_class"}, 32'({bus.is_rtype, bus.is_jtype, bus.is_branch, bus.is_mem}), 32'd0);
`endif
   endtask

   initial begin
      //           instr         op     rs     rt     rd     sh     fn     imm       ext            jt            cls
      vecs[0]  = '{32'h00221820, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h1820, 32'h00001820, 26'h0221820, 4'b1000};
      vecs[1]  = '{32'h2022FFFF, 6'h08, 5'd1,  5'd2,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 32'hFFFFFFFF, 26'h022FFFF, 4'b0000};
      vecs[2]  = '{32'h3422FFFF, 6'h0D, 5'd1,  5'd2,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 32'h0000FFFF, 26'h022FFFF, 4'b0000};
      vecs[3]  = '{32'h3C011234, 6'h0F, 5'd0,  5'd1,  5'd2,  5'd8,  6'h34, 16'h1234, 32'h12340000, 26'h0011234, 4'b0000};
      vecs[4]  = '{32'h08000010, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h10, 16'h0010, 32'h00000010, 26'h0000010, 4'b0100};
      vecs[5]  = '{32'h8C220004, 6'h23, 5'd1,  5'd2,  5'd0,  5'd0,  6'h04, 16'h0004, 32'h00000004, 26'h0220004, 4'b0001};
      vecs[6]  = '{32'h3082FFFF, 6'h0C, 5'd4,  5'd2,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 32'h0000FFFF, 26'h082FFFF, 4'b0000};
      vecs[7]  = '{32'h38A58000, 6'h0E, 5'd5,  5'd5,  5'd16, 5'd0,  6'h00, 16'h8000, 32'h00008000, 26'h0A58000, 4'b0000};
      vecs[8]  = '{32'h1085FFFE, 6'h04, 5'd4,  5'd5,  5'd31, 5'd31, 6'h3E, 16'hFFFE, 32'hFFFFFFFE, 26'h085FFFE, 4'b0010};
      vecs[9]  = '{32'h0420FF00, 6'h01, 5'd1,  5'd0,  5'd31, 5'd28, 6'h00, 16'hFF00, 32'hFFFFFF00, 26'h020FF00, 4'b0010};
      vecs[10] = '{32'hAC43FFF8, 6'h2B, 5'd2,  5'd3,  5'd31, 5'd31, 6'h38, 16'hFFF8, 32'hFFFFFFF8, 26'h043FFF8, 4'b0001};
      vecs[11] = '{32'h0FFFFFFF, 6'h03, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 32'hFFFFFFFF, 26'h3FFFFFF, 4'b0100};

      rst = 1'b1; state = 3'd0; flush = 1'b0;
      bus.in_valid = 1'b0; bus.instruction = '0; bus.out_ready = 1'b0;
      repeat (3) step();
      check("reset_in_ready", 32'(bus.in_ready), 32'd0);
      check_zero_outputs("reset");
      rst = 1'b0;
      step();
      check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

      // Single R-type word: visible one edge after acceptance, not sooner.
      state = 3'd1; bus.out_ready = 1'b1;
      push_vec(0);
      check("t1_not_yet_valid", 32'(bus.out_valid), 32'd0);
      check("t1_count_one",     32'(bus.count),     32'd1);
      step();
      check("t1_valid",         32'(bus.out_valid), 32'd1);
      check("t1_count_zero",    32'(bus.count),     32'd0);
      drain();

      // Streaming through all extension / classification patterns.
      for (int i = 1; i < 12; i++) push_vec(i);
      drain();
      step();
      check("stream_idle_valid", 32'(bus.out_valid), 32'd0);
      check("stream_hold_op",    32'(bus.opcode),    32'h03);

      // Fill under backpressure: 1 in the output register + 4 in the FIFO.
      bus.out_ready = 1'b0;
      push_vec(1); push_vec(2); push_vec(3); push_vec(5); push_vec(8);
      check("full_count",    32'(bus.count),     32'd4);
      check("full_in_ready", 32'(bus.in_ready),  32'd0);
      bus.instruction = vecs[0].instr; bus.in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("stall_in_ready", 32'(bus.in_ready), 32'd0);
         check("stall_opcode",   32'(bus.opcode),   32'h08);
         check("stall_imm_ext",  bus.imm_ext,       32'hFFFFFFFF);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      drain();

      // Decode held off outside FIELDS_STATE, then consecutive loads.
      state = 3'd0;
      push_vec(6); push_vec(7);
      step(); step();
      check("hold_count", 32'(bus.count),     32'd2);
      check("hold_valid", 32'(bus.out_valid), 32'd0);
      state = 3'd1;
      step();
      check("resume_a_op",    32'(bus.opcode), 32'h0C);
      check("resume_a_count", 32'(bus.count),  32'd1);
      step();
      check("resume_b_op",    32'(bus.opcode), 32'h0E);
      check("resume_b_count", 32'(bus.count),  32'd0);
      drain();

      // Flush with count=3 and out_valid=1; the word offered during flush is dropped.
      bus.out_ready = 1'b0;
      push_vec(9); push_vec(10); push_vec(11); push_vec(0);
      check("pre_flush_count", 32'(bus.count),     32'd3);
      check("pre_flush_valid", 32'(bus.out_valid), 32'd1);
      flush = 1'b1; bus.in_valid = 1'b1; bus.instruction = vecs[4].instr;
      sb.delete();
      #1;
      check("flush_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      flush = 1'b0; bus.in_valid = 1'b0;
      check("flush_count",      32'(bus.count),     32'd0);
      check("flush_valid",      32'(bus.out_valid), 32'd0);
      check("flush_hold_op",    32'(bus.opcode),    32'h01);
      check("flush_hold_ext",   bus.imm_ext,        32'hFFFFFF00);
      bus.out_ready = 1'b1;
      push_vec(4);
      drain();

      // Reset in the middle of traffic.
      bus.out_ready = 1'b0;
      push_vec(3); push_vec(5);
      rst = 1'b1;
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      sb.delete();
      check_zero_outputs("midrst");
      rst = 1'b0;
      bus.out_ready = 1'b1;
      push_vec(5);
      drain();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
